// File: rtl/cxs_txflit_sched.sv
// CXS TX flit read sequencer: fetches descriptor flits from RAM port B and sends them under credit control.
// Optional counters are enabled with `define CXS_TXSCHED_STATS_EN.
module cxs_txflit_sched #(
   parameter int AWIDTH     = 12,
   parameter int DWIDTH     = 256,
   parameter int RD_LAT     = 2,
   parameter int MAX_CREDIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [AWIDTH-1:0] desc_addr,
   input  logic [7:0]        desc_len,
   output logic              done,
   output logic              ram_en_b,
   output logic              ram_we_b,
   output logic              ram_oreg_ce_b,
   output logic [AWIDTH-1:0] ram_addr_b,
   input  logic [DWIDTH-1:0] ram_rd_data,
   output logic              cxs_tx_valid,
   output logic [DWIDTH-1:0] cxs_tx_data,
   output logic              cxs_tx_last,
   input  logic              cxs_crdgnt,
   output logic [3:0]        crd_cnt,
`ifdef CXS_TXSCHED_STATS_EN
   output logic [31:0]       stat_flits,
   output logic [31:0]       stat_stall,
   output logic [15:0]       stat_desc,
`endif
   output logic              crd_err
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q;
   logic [AWIDTH-1:0] cur_addr_q;
   logic [7:0]        remain_q;
   logic [3:0]        crd_q;
   logic [3:0]        crd_d;
   logic              crd_err_q;
   logic [RD_LAT-1:0] pipe_vld_q;
   logic [RD_LAT-1:0] pipe_last_q;
   logic              issue;
   logic              last_out;

   // Credit is reserved at issue time, so every flit in flight already owns a receiver slot.
   assign issue    = (state_q == FETCH) && (crd_q != 4'd0);
   assign last_out = pipe_vld_q[RD_LAT-1] & pipe_last_q[RD_LAT-1];

   always_comb begin
      crd_d = crd_q;
      if (cxs_crdgnt && !issue) begin
         if (crd_q != 4'(MAX_CREDIT))
            crd_d = crd_q + 4'd1;
      end else if (!cxs_crdgnt && issue) begin
         crd_d = crd_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remain_q    <= '0;
         crd_q       <= '0;
         crd_err_q   <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
      end else begin
         crd_q <= crd_d;
         if (cxs_crdgnt && !issue && (crd_q == 4'(MAX_CREDIT)))
            crd_err_q <= 1'b1;

         pipe_vld_q[0]  <= issue;
         pipe_last_q[0] <= issue && (remain_q == 8'd0);
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end

         case (state_q)
            IDLE: begin
               if (desc_valid) begin
                  cur_addr_q <= desc_addr;
                  remain_q   <= desc_len;
                  state_q    <= FETCH;
               end
            end
            FETCH: begin
               if (issue) begin
                  cur_addr_q <= cur_addr_q + AWIDTH'(1);
                  if (remain_q == 8'd0)
                     state_q <= DRAIN;
                  else
                     remain_q <= remain_q - 8'd1;
               end
            end
            DRAIN: begin
               if (last_out)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign desc_ready    = (state_q == IDLE) && !rst;
   assign done          = (state_q == DRAIN) && last_out;
   assign ram_en_b      = issue;
   assign ram_we_b      = 1'b0;
   assign ram_oreg_ce_b = 1'b1;
   assign ram_addr_b    = cur_addr_q;
   assign cxs_tx_valid  = pipe_vld_q[RD_LAT-1];
   assign cxs_tx_last   = pipe_last_q[RD_LAT-1];
   assign cxs_tx_data   = ram_rd_data;
   assign crd_cnt       = crd_q;
   assign crd_err       = crd_err_q;

`ifdef CXS_TXSCHED_STATS_EN
   logic [31:0] stat_flits_q;
   logic [31:0] stat_stall_q;
   logic [15:0] stat_desc_q;

   // Free-running activity counters; they wrap silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_flits_q <= '0;
         stat_stall_q <= '0;
         stat_desc_q  <= '0;
      end else begin
         if (cxs_tx_valid)
            stat_flits_q <= stat_flits_q + 32'd1;
         if ((state_q == FETCH) && (crd_q == 4'd0))
            stat_stall_q <= stat_stall_q + 32'd1;
         if (done)
            stat_desc_q <= stat_desc_q + 16'd1;
      end
   end

   assign stat_flits = stat_flits_q;
   assign stat_stall = stat_stall_q;
   assign stat_desc  = stat_desc_q;
`endif

endmodule
